// File: rtl/juego_pkg.sv
// Shared types and constants for the 2048 turn sequencer: move codes, FSM states, board size.
package juego_pkg;

  typedef enum logic [2:0] {
    QUIETO = 3'b000,
    IZQ    = 3'b001,
    DER    = 3'b010,
    ARRIBA = 3'b011,
    ABAJO  = 3'b100
  } mov_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MOVE,
    S_WAIT,
    S_SPAWN,
    S_SETTLE,
    S_WON,
    S_LOST
  } state_t;

  localparam int BOARD_CELLS = 16;
  localparam int WIN_EXP_DEF = 11;

  function automatic logic dir_legal(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/control_juego_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running; SEED must be nonzero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;
  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[14:0], fb};
  end

endmodule

// File: rtl/control_juego.sv
// 2048 turn sequencer: move handshake, saturating score, random tile spawn, win/loss evaluation.
// Optional macro SPAWN_FOUR_EN: spawn a 4-tile on 1/8 of spawns (default build always spawns a 2).
module control_juego
  import juego_pkg::*;
#(
  parameter int          SCORE_W   = 20,
  parameter int          WIN_EXP   = WIN_EXP_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_valid,
  input  logic [2:0]         btn_dir,
  input  logic               new_game,
  output logic [2:0]         mov,
  output logic               mov_start,
  input  logic               mov_done,
  input  logic               mov_changed,
  input  logic [15:0]        mov_points,
  input  logic [15:0]        empty_mask,
  input  logic [3:0]         max_exp,
  input  logic               can_merge,
  output logic               board_clr,
  output logic               spawn_we,
  output logic [3:0]         spawn_idx,
  output logic [3:0]         spawn_exp,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               won,
  output logic               lost,
  output state_t             dbg_state
);

  state_t             state, state_n;
  mov_t               mov_lat;
  logic [15:0]        lfsr;
  logic [SCORE_W-1:0] score_r;
  logic [1:0]         spawns_left, spawns_left_n;
  logic [3:0]         scan_idx, scan_idx_n, scan_cnt, scan_cnt_n;
  logic               board_clr_r;
  logic               hit;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_sat;
  logic [3:0]         exp_sel;
  logic               unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];
  assign hit         = empty_mask[scan_idx];
  assign sum         = {1'b0, score_r} + (SCORE_W+1)'(mov_points);
  assign score_sat   = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

`ifdef SPAWN_FOUR_EN
  assign exp_sel = (lfsr[6:4] == 3'b000) ? 4'd2 : 4'd1;
`else
  assign exp_sel = 4'd1;
`endif

  always_comb begin
    state_n       = state;
    spawns_left_n = spawns_left;
    scan_idx_n    = scan_idx;
    scan_cnt_n    = scan_cnt;
    spawn_we      = 1'b0;
    case (state)
      // board_clr is registered so it stays low during reset; INIT only
      // advances once the clear pulse is actually on the wire.
      S_INIT: begin
        if (board_clr_r) begin
          spawns_left_n = 2'd2;
          state_n       = S_SPAWN;
        end
      end
      S_IDLE: begin
        if (new_game)                               state_n = S_INIT;
        else if (btn_valid && dir_legal(btn_dir))   state_n = S_MOVE;
      end
      S_MOVE: state_n = S_WAIT;
      // Handshake: mov_start pulses once in MOVE; mov is held through WAIT and the
      // datapath answers with mov_done (mov_changed/mov_points valid with it), no backpressure.
      S_WAIT: begin
        if (mov_done) begin
          if (mov_changed) begin
            spawns_left_n = 2'd1;
            state_n       = S_SPAWN;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_SPAWN: begin
        if (hit) begin
          spawn_we      = 1'b1;
          spawns_left_n = spawns_left - 2'd1;
          state_n       = S_SETTLE;
        end else if (scan_cnt == 4'(BOARD_CELLS - 1)) begin
          spawns_left_n = 2'd0;
          state_n       = S_SETTLE;
        end else begin
          scan_idx_n = scan_idx + 4'd1;
          scan_cnt_n = scan_cnt + 4'd1;
        end
      end
      S_SETTLE: begin
        if (spawns_left != 2'd0)                     state_n = S_SPAWN;
        else if (int'(max_exp) >= WIN_EXP)           state_n = S_WON;
        else if (empty_mask == 16'd0 && !can_merge)  state_n = S_LOST;
        else                                         state_n = S_IDLE;
      end
      S_WON, S_LOST: begin
        if (new_game) state_n = S_INIT;
      end
      default: state_n = S_INIT;
    endcase
    // Each entry into SPAWN restarts the scan at a random cell.
    if (state_n == S_SPAWN && state != S_SPAWN) begin
      scan_idx_n = lfsr[3:0];
      scan_cnt_n = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      mov_lat     <= QUIETO;
      score_r     <= '0;
      spawns_left <= 2'd0;
      scan_idx    <= 4'd0;
      scan_cnt    <= 4'd0;
      board_clr_r <= 1'b0;
    end else begin
      state       <= state_n;
      spawns_left <= spawns_left_n;
      scan_idx    <= scan_idx_n;
      scan_cnt    <= scan_cnt_n;
      board_clr_r <= (state_n == S_INIT);
      if (state == S_IDLE && state_n == S_MOVE) mov_lat <= mov_t'(btn_dir);
      if (state == S_INIT && board_clr_r)       score_r <= '0;
      else if (state == S_WAIT && mov_done)     score_r <= score_sat;
    end
  end

  assign mov       = (state == S_MOVE || state == S_WAIT) ? mov_lat : QUIETO;
  assign mov_start = (state == S_MOVE);
  assign board_clr = board_clr_r;
  assign spawn_idx = scan_idx;
  assign spawn_exp = spawn_we ? exp_sel : 4'd0;
  assign score     = score_r;
  assign busy      = !(state == S_IDLE || state == S_WON || state == S_LOST);
  assign won       = (state == S_WON);
  assign lost      = (state == S_LOST);
  assign dbg_state = state;

endmodule

// File: tb/tb_control_juego.sv
// Bench for control_juego: scoreboard queues for score and directed spawn cells, bounded waits.
module tb_control_juego;
  import juego_pkg::*;

  localparam int SCORE_W = 20;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               btn_valid, new_game, mov_done, mov_changed, can_merge;
  logic [2:0]         btn_dir, mov;
  logic [15:0]        mov_points, empty_mask;
  logic [3:0]         max_exp, spawn_idx, spawn_exp;
  logic               mov_start, board_clr, spawn_we, busy, won, lost;
  logic [SCORE_W-1:0] score;
  state_t             dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SCORE_W-1:0] exp_q[$];
  logic [3:0]         idx_q[$];
  int   score_model;
  int   spawn_cnt, clr_cnt, start_cnt, spawn_cycles;
  bit   score_due = 1'b0;

  control_juego #(.SCORE_W(SCORE_W)) dut (
    .clk (clk), .rst (rst), .btn_valid (btn_valid), .btn_dir (btn_dir),
    .new_game (new_game), .mov (mov), .mov_start (mov_start), .mov_done (mov_done),
    .mov_changed (mov_changed), .mov_points (mov_points), .empty_mask (empty_mask),
    .max_exp (max_exp), .can_merge (can_merge), .board_clr (board_clr),
    .spawn_we (spawn_we), .spawn_idx (spawn_idx), .spawn_exp (spawn_exp),
    .score (score), .busy (busy), .won (won), .lost (lost), .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: spawn writes, pulse counters, score popped the cycle after an accepted mov_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (spawn_we) begin
        spawn_cnt++;
        check("spawn_exp", spawn_exp, 32'd1);
        check("spawn_in_empty", empty_mask[spawn_idx], 32'd1);
        if (idx_q.size() > 0) check("spawn_idx", spawn_idx, idx_q.pop_front());
      end
      if (board_clr) clr_cnt++;
      if (mov_start) start_cnt++;
      if (dbg_state == S_SPAWN) spawn_cycles++;
      if (score_due) begin
        if (exp_q.size() == 0) check("score_sb_empty", exp_q.size(), 32'd1);
        else                   check("score", score, exp_q.pop_front());
      end
      score_due = mov_done && (dbg_state == S_WAIT);
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 32'd0);
  endtask

  task automatic do_move(input logic [2:0] dir, input logic [15:0] pts,
                         input logic chg, input logic poke);
    int nxt;
    @(posedge clk); #1;
    btn_valid = 1'b1; btn_dir = dir;
    @(posedge clk); #1;
    btn_valid = 1'b0;
    @(negedge clk);
    check("mov_start", mov_start, 32'd1);
    check("mov_in_move", mov, dir);
    @(posedge clk); #1;
    if (poke) begin
      btn_valid = 1'b1; btn_dir = IZQ;
      @(posedge clk); #1;
      btn_valid = 1'b0;
    end
    mov_done = 1'b1; mov_points = pts; mov_changed = chg;
    nxt = score_model + int'(pts);
    score_model = (nxt > SCORE_MAX) ? SCORE_MAX : nxt;
    exp_q.push_back(SCORE_W'(score_model));
    @(negedge clk);
    check("mov_held", mov, dir);
    check("mov_start_low", mov_start, 32'd0);
    @(posedge clk); #1;
    mov_done = 1'b0; mov_points = 16'd0; mov_changed = 1'b0;
  endtask

  task automatic pulse_new_game(input logic with_btn);
    @(posedge clk); #1;
    new_game = 1'b1;
    if (with_btn) begin btn_valid = 1'b1; btn_dir = DER; end
    @(posedge clk); #1;
    new_game = 1'b0; btn_valid = 1'b0;
    score_model = 0;
    @(negedge clk);
    check("ng_board_clr", board_clr, 32'd1);
    check("ng_state", dbg_state, S_INIT);
    check("ng_no_start", mov_start, 32'd0);
  endtask

  logic [15:0] masks [4] = '{16'h0100, 16'h0001, 16'h8000, 16'h0010};
  logic [3:0]  idxs  [4] = '{4'd8, 4'd0, 4'd15, 4'd4};
  logic [2:0]  illegal [4] = '{3'd0, 3'd5, 3'd6, 3'd7};

  initial begin
    int s, target;
    rst = 1'b1;
    btn_valid = 0; btn_dir = 0; new_game = 0; mov_done = 0; mov_changed = 0;
    mov_points = 0; empty_mask = 16'hFFFF; max_exp = 0; can_merge = 0;
    score_model = 0; spawn_cnt = 0; clr_cnt = 0; start_cnt = 0; spawn_cycles = 0;

    repeat (2) @(negedge clk);
    check("rst_mov", mov, 32'd0);
    check("rst_mov_start", mov_start, 32'd0);
    check("rst_board_clr", board_clr, 32'd0);
    check("rst_spawn_we", spawn_we, 32'd0);
    check("rst_spawn_idx", spawn_idx, 32'd0);
    check("rst_spawn_exp", spawn_exp, 32'd0);
    check("rst_won", won, 32'd0);
    check("rst_lost", lost, 32'd0);
    check("rst_score", score, 32'd0);
    check("rst_state", dbg_state, S_INIT);

    @(posedge clk); #1 rst = 1'b0;
    wait_idle("init_idle", 80);
    check("init_clr_cnt", clr_cnt, 32'd1);
    check("init_spawns", spawn_cnt, 32'd2);
    check("init_state", dbg_state, S_IDLE);
    check("init_mov", mov, 32'd0);

    spawn_cnt = 0;
    do_move(IZQ, 16'd8, 1'b1, 1'b0);
    wait_idle("move1_idle", 40);
    check("move1_spawns", spawn_cnt, 32'd1);
    check("move1_score", score, 32'd8);

    for (int i = 0; i < 4; i++) begin
      empty_mask = masks[i];
      idx_q.push_back(idxs[i]);
      spawn_cnt = 0;
      do_move(3'(i + 1), 16'(4 * i), 1'b1, 1'b0);
      wait_idle("dir_idle", 40);
      check("dir_spawns", spawn_cnt, 32'd1);
    end

    empty_mask = 16'h0000; can_merge = 1'b1;
    spawn_cnt = 0; spawn_cycles = 0;
    do_move(ARRIBA, 16'd4, 1'b1, 1'b0);
    wait_idle("full_idle", 40);
    check("full_no_spawn", spawn_cnt, 32'd0);
    check("full_scan_cycles", spawn_cycles, 32'd16);
    check("full_not_lost", lost, 32'd0);
    empty_mask = 16'hFFFF; can_merge = 1'b0;

    s = start_cnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      btn_valid = 1'b1; btn_dir = illegal[i];
      @(posedge clk); #1;
      btn_valid = 1'b0;
      @(negedge clk);
      check("illegal_state", dbg_state, S_IDLE);
    end
    check("illegal_no_start", start_cnt, s);

    s = start_cnt; spawn_cnt = 0;
    do_move(ABAJO, 16'd2, 1'b0, 1'b1);
    @(negedge clk);
    check("nochg_state", dbg_state, S_IDLE);
    repeat (3) @(negedge clk);
    check("nochg_spawns", spawn_cnt, 32'd0);
    check("wait_poke_ignored", start_cnt, s + 1);

    target = SCORE_MAX - 3 - score_model;
    while (target > 0) begin
      s = (target > 65535) ? 65535 : target;
      do_move(DER, 16'(s), 1'b0, 1'b0);
      target -= s;
      wait_idle("sat_idle", 10);
    end
    check("sat_pre", score, SCORE_MAX - 3);
    do_move(IZQ, 16'd16, 1'b0, 1'b0);
    wait_idle("sat_idle2", 10);
    check("sat_score", score, 32'hFFFFF);

    max_exp = 4'd11; spawn_cnt = 0;
    do_move(IZQ, 16'd0, 1'b1, 1'b0);
    wait_idle("win_settle", 40);
    check("win_won", won, 32'd1);
    check("win_lost", lost, 32'd0);
    check("win_state", dbg_state, S_WON);
    check("win_spawns", spawn_cnt, 32'd1);
    s = start_cnt;
    @(posedge clk); #1 btn_valid = 1'b1; btn_dir = IZQ;
    @(posedge clk); #1 btn_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("won_hold", dbg_state, S_WON);
    check("won_no_start", start_cnt, s);
    max_exp = 4'd0; clr_cnt = 0;
    pulse_new_game(1'b0);
    wait_idle("won_restart", 80);
    check("won_restart_score", score, 32'd0);
    check("won_restart_won", won, 32'd0);
    check("won_restart_clr", clr_cnt, 32'd1);

    empty_mask = 16'h0000; can_merge = 1'b0;
    do_move(DER, 16'd4, 1'b1, 1'b0);
    wait_idle("lose_settle", 40);
    check("lose_lost", lost, 32'd1);
    check("lose_won", won, 32'd0);
    check("lose_state", dbg_state, S_LOST);
    check("lose_score", score, 32'd4);
    empty_mask = 16'hFFFF;
    pulse_new_game(1'b0);
    wait_idle("lose_restart", 80);
    check("lose_restart_score", score, 32'd0);
    check("lose_restart_lost", lost, 32'd0);

    pulse_new_game(1'b1);
    wait_idle("prio_restart", 80);

    do_move(ABAJO, 16'd6, 1'b0, 1'b0);
    wait_idle("pre_rst_idle", 10);
    @(posedge clk); #1 btn_valid = 1'b1; btn_dir = IZQ;
    @(posedge clk); #1 btn_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("arst_state", dbg_state, S_INIT);
    check("arst_mov", mov, 32'd0);
    check("arst_board_clr", board_clr, 32'd0);
    check("arst_score", score, 32'd0);
    score_model = 0;
    @(posedge clk); #1 rst = 1'b0;
    wait_idle("arst_idle", 80);
    check("arst_after_score", score, 32'd0);

    check("score_q_left", exp_q.size(), 32'd0);
    check("idx_q_left", idx_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_juego.md
# control_juego

Turn sequencer for the 4x4 2048 game. It accepts a direction command, drives the movement datapath through a start/done handshake, and accumulates the score from merged tiles. After each move it spawns a new tile into a pseudo-randomly chosen empty cell, then evaluates the win and loss conditions. It sits between the debounced button front-end and the board/movement datapath, and owns the game-level state.

## Interface
- `SCORE_W`, default 20: score accumulator width; saturating.
- `WIN_EXP`, default 11: tile exponent that wins the game (2^11 = 2048).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_valid` in 1: one-cycle command pulse.
- `btn_dir` in 3: direction code. 001 left, 010 right, 011 up, 100 down. Codes 000 and 101–111 are ignored.
- `new_game` in 1: one-cycle restart request.
- `mov` out 3: move code to the datapath; 000 when not moving.
- `mov_start` out 1: one-cycle start pulse.
- `mov_done` in 1: datapath finished the move.
- `mov_changed` in 1: board changed; valid with `mov_done`.
- `mov_points` in 16: sum of merged tile values; valid with `mov_done`.
- `empty_mask` in 16: bit i set means cell i is empty.
- `max_exp` in 4: largest tile exponent on the board.
- `can_merge` in 1: at least one adjacent equal pair exists.
- `board_clr` out 1: one-cycle board clear pulse.
- `spawn_we` out 1: one-cycle tile write.
- `spawn_idx` out 4: cell index for the tile write.
- `spawn_exp` out 4: exponent to write (1 means tile 2, 2 means tile 4).
- `score` out SCORE_W: current score.
- `busy` out 1: high in any state except IDLE, WON, LOST.
- `won` out 1: high in WON.
- `lost` out 1: high in LOST.

## Operation
- States: INIT, IDLE, MOVE, WAIT, SPAWN, SETTLE, WON, LOST.
- Reset: state INIT; `score`=0; LFSR=`LFSR_SEED`; `spawns_left`=0.
  - Reset values of outputs: `mov`=000; `mov_start`, `board_clr`, `spawn_we`, `won`, `lost` = 0; `spawn_idx`=0; `spawn_exp`=0.
- INIT (1 cycle): assert `board_clr`, clear `score`, set `spawns_left`=2, go to SPAWN.
- IDLE:
  - `new_game` goes to INIT. It has priority over a simultaneous `btn_valid`.
  - `btn_valid` with a legal `btn_dir` latches the code and goes to MOVE.
  - `btn_valid` with an illegal code is ignored.
- MOVE (1 cycle): `mov_start`=1, `mov`=latched code, go to WAIT.
- WAIT:
  - `mov` stays held. Wait indefinitely for `mov_done`.
  - On `mov_done`: `score` becomes `score`+`mov_points`, saturating at all-ones.
  - If `mov_changed`=1: set `spawns_left`=1 and go to SPAWN. Otherwise go to IDLE.
- SPAWN: sequential scan for an empty cell.
  - On entry: `scan_idx`=LFSR[3:0], `scan_cnt`=0.
  - Each cycle, if `empty_mask[scan_idx]` is set: assert `spawn_we` with `spawn_idx`=`scan_idx`, decrement `spawns_left`, go to SETTLE.
  - Otherwise `scan_idx` increments mod 16 (15 wraps to 0) and `scan_cnt` increments.
  - `scan_cnt`=15 with no hit: no write, `spawns_left`=0, go to SETTLE.
- SETTLE (1 cycle; lets the board flags reflect the write):
  - `spawns_left`>0: go to SPAWN.
  - else `max_exp`>=`WIN_EXP`: go to WON.
  - else `empty_mask`=0 and `can_merge`=0: go to LOST.
  - else go to IDLE.
- WON and LOST hold until `new_game`, which goes to INIT. `btn_valid` is ignored there.
- `btn_valid` and `new_game` are dropped in every state other than those listed above; commands are not queued.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including while idle.

## Timing
- `btn_valid` accepted at cycle t: `mov_start` is high at t+1; `mov` is valid from t+1 until the cycle `mov_done` is sampled.
- `mov_done` is sampled only in WAIT, so the earliest effective `mov_done` is at t+2. `score` updates on the edge after `mov_done`.
- Spawn after a move: `spawn_we` appears 1–16 cycles after WAIT exits. SETTLE follows, then the evaluation, for 2 cycles minimum before IDLE/WON/LOST.
- INIT to IDLE: 1 + 2×(1..16 + 1) cycles.
- Asynchronous reset mid-operation: immediate return to INIT and all outputs return to their reset values. The datapath is not notified beyond `board_clr` in INIT.

## Configuration
- `SPAWN_FOUR_EN` defined: `spawn_exp`=2 when LFSR[6:4]=000 (1/8 of spawns), else 1.
- `SPAWN_FOUR_EN` undefined: `spawn_exp` is always 1.

## Structure
- Shared package `juego_pkg`:
  - `mov_t` enum: QUIETO=000, IZQ=001, DER=010, ARRIBA=011, ABAJO=100.
  - state enum.
  - `BOARD_CELLS`=16.
  - default `WIN_EXP`.
- Sub-module `lfsr16`: ports `clk`, `rst`, SEED parameter, 16-bit output.

## Test plan
- Reset release with `empty_mask`=FFFF: `board_clr` pulse, exactly two `spawn_we` pulses, `spawn_exp`=1 (macro off), then IDLE with `busy`=0.
- `btn_dir`=001 accepted in IDLE: `mov_start` 1 cycle later with `mov`=001; `mov_done` with `mov_points`=8 and `mov_changed`=1 gives `score`=8 and one spawn.
- `empty_mask`=16'h0100 during SPAWN: `spawn_idx`=8 for any LFSR start. `empty_mask`=0 during SPAWN: no write after 16 cycles.
- Score saturation: `score` at 2^20−4 plus `mov_points`=16 gives `score`=FFFFF.
- `mov_changed`=0: no spawn, back to IDLE; `btn_valid` during WAIT is ignored.
- `max_exp`=11 after spawn gives `won`=1. Full board with `can_merge`=0 gives `lost`=1. `new_game` from either reaches INIT with `score`=0.
